avalon_st_channel_remap_buffer: RTL
===================================

Name: avalon_st_channel_remap_buffer

Overview:
- Parametrised Avalon-ST channel adapter between a narrow-channel source and a wider-channel sink.
- Adds a per-packet channel offset, checks the result against a legal range, and drops illegal or orphan packets.
- Registers the output through a 2-entry skid buffer, so both ready and valid paths are broken.
- Sits on the streaming fabric between the packet source and the channelised sink/demux; successor of the fixed 1-to-2-bit pass-through adapter.

Parameters:
- DATA_W, 32, payload width.
- ERR_W, 6, error sideband width.
- IN_CH_W, 1, input channel width (>=1).
- OUT_CH_W, 2, output channel width (>= IN_CH_W).
- CH_OFFSET, 0, constant added to the input channel.
- MAX_OUT_CH, 3, highest legal output channel (<= 2^OUT_CH_W-1).
- CNT_W, 16, width of the drop counter.

Ports:
- clk, in, 1, single clock.
- reset_n, in, 1, asynchronous active-low reset.
- in_ready, out, 1, sink ready to upstream.
- in_valid, in, 1, input beat valid.
- in_data, in, DATA_W, input payload.
- in_channel, in, IN_CH_W, input channel (sampled on SOP beat only).
- in_error, in, ERR_W, input error sideband.
- in_startofpacket, in, 1, input SOP.
- in_endofpacket, in, 1, input EOP.
- out_ready, in, 1, downstream ready.
- out_valid, out, 1, output beat valid.
- out_data, out, DATA_W, output payload.
- out_channel, out, OUT_CH_W, remapped channel.
- out_error, out, ERR_W, output error sideband.
- out_startofpacket, out, 1, output SOP.
- out_endofpacket, out, 1, output EOP.
- drop_count, out, CNT_W, saturating count of dropped packets.

Behaviour:
- Reset, asynchronous, reset_n=0: buffer count=0, out_valid=0, in_ready=0, all out_* payload/sideband=0, drop_count=0, FSM=IDLE.
- in_ready rises in the first cycle after reset release.
- Reset asserted mid-packet discards buffer contents and FSM state immediately. The next accepted beat must carry SOP; otherwise it is treated as an orphan.
- Accept: a beat is accepted when in_valid && in_ready.
- in_ready is registered and equals (buffer count < 2) evaluated at the previous edge. The skid entry absorbs the one beat in flight.
- Output: out_valid = (count > 0); the head entry drives out_*. A beat leaves on out_valid && out_ready.
- Latency: accepted beat appears on out_* the next cycle (1 cycle) when the buffer is empty.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- Order preserved. Simultaneous push and pop keeps the count unchanged.
- Remap: sum = zero-extended in_channel + CH_OFFSET, computed in OUT_CH_W+1 bits; legal iff sum <= MAX_OUT_CH.
- The channel is latched on the SOP beat and applied to every beat of that packet. in_channel on non-SOP beats is ignored.
- FSM IDLE:
  - SOP beat with legal channel: push it. If EOP is not also set, go to PASS; SOP+EOP stays in IDLE.
  - SOP beat with illegal channel: do not push, drop_count+1. If EOP is not also set, go to DROP.
  - Non-SOP beat (orphan): do not push, drop_count+1. If EOP is not also set, go to DROP.
- FSM PASS: push every beat with the latched channel; EOP returns to IDLE.
- FSM PASS, SOP arriving before EOP: close the open packet by pushing this beat with out_endofpacket=1, out_startofpacket=0 and out_error bit 0 forced to 1. Then re-evaluate the beat as a new packet in the next cycle; the beat is held by deasserting in_ready for 1 cycle.
- FSM DROP: discard beats until EOP, then go to IDLE. A SOP seen in DROP restarts evaluation as in IDLE.
- drop_count saturates at 2^CNT_W-1 with no wrap. One increment per dropped packet, not per beat.
- Dropped beats are accepted (in_ready unaffected) and never reach the buffer.
- Error sideband passes through unchanged except for the forced bit 0 above.

Decomposition:
- Shared package: FSM state enum {IDLE, PASS, DROP}.
- Sub-module avalon_st_skid_buffer (parameter WIDTH, 2 entries, registered ready). The adapter instantiates it with WIDTH = DATA_W+ERR_W+OUT_CH_W+2.

Test Plan:
- Defaults, CH_OFFSET=1, MAX_OUT_CH=3: 4-beat packet on in_channel=1, out_ready=1 -> 4 beats, out_channel=2, SOP on beat 0, EOP on beat 3, first beat 1 cycle after accept, drop_count=0.
- CH_OFFSET=3, in_channel=1 (sum=4>3): 3-beat packet -> no output beats, drop_count=1; following legal packet passes intact.
- Back-pressure: out_ready toggling 1/0 each cycle during a 16-beat packet, data 0..15 -> in_ready deasserts only at count=2, output data 0..15 in order, none lost or duplicated.
- Orphan: beat without SOP from IDLE, then SOP+EOP single-beat packet data 0xA5 -> orphan dropped (drop_count=1), 0xA5 output with SOP=EOP=1.
- PASS, new SOP before EOP -> previous packet closed with EOP=1, out_error[0]=1; new packet follows with its own SOP and channel.
- CNT_W=2: six illegal packets -> drop_count=3, held. reset_n pulse mid-packet -> out_valid=0 asynchronously, drop_count=0.

Source files
------------

// File: rtl/avalon_st_channel_remap_buffer_pkg.sv
// Shared types for the Avalon-ST channel remap adapter.
// Packet FSM states used by the adapter front end.
package avalon_st_channel_remap_buffer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PASS = 2'd1,
      ST_DROP = 2'd2
   } remap_state_e;

endpackage

// File: rtl/avalon_st_skid_buffer.sv
// Two-entry skid buffer with a registered ready.
// Breaks both the valid and the ready timing paths.
module avalon_st_skid_buffer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;
   logic [1:0]       count_d;
   logic             ready_q;
   logic             push;
   logic             pop;

   assign push      = in_valid & ready_q;
   assign pop       = out_valid & out_ready;
   assign out_valid = (count_q != 2'd0);
   assign out_data  = mem_q[rd_ptr_q];
   assign in_ready  = ready_q;

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // ready looks at the post-edge occupancy so a full buffer never overflows
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         ready_q  <= 1'b0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= in_data;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_d;
         ready_q <= (count_d != 2'd2);
      end
   end

endmodule

// File: rtl/avalon_st_channel_remap_buffer.sv
// Avalon-ST channel remap: offsets the packet channel, drops illegal
// and orphan packets, and registers the result through a skid buffer.
module avalon_st_channel_remap_buffer
   import avalon_st_channel_remap_buffer_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ERR_W      = 6,
   parameter int IN_CH_W    = 1,
   parameter int OUT_CH_W   = 2,
   parameter int CH_OFFSET  = 0,
   parameter int MAX_OUT_CH = 3,
   parameter int CNT_W      = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   output logic                in_ready,
   input  logic                in_valid,
   input  logic [DATA_W-1:0]   in_data,
   input  logic [IN_CH_W-1:0]  in_channel,
   input  logic [ERR_W-1:0]    in_error,
   input  logic                in_startofpacket,
   input  logic                in_endofpacket,
   input  logic                out_ready,
   output logic                out_valid,
   output logic [DATA_W-1:0]   out_data,
   output logic [OUT_CH_W-1:0] out_channel,
   output logic [ERR_W-1:0]    out_error,
   output logic                out_startofpacket,
   output logic                out_endofpacket,
   output logic [CNT_W-1:0]    drop_count
);

   localparam int SUM_W = OUT_CH_W + 1;
   localparam int BUF_W = DATA_W + ERR_W + OUT_CH_W + 2;

   remap_state_e state_q;
   remap_state_e state_d;

   logic                buf_ready;
   logic                hold_q;
   logic [DATA_W-1:0]   hold_data_q;
   logic [ERR_W-1:0]    hold_err_q;
   logic [IN_CH_W-1:0]  hold_ch_q;
   logic                hold_eop_q;
   logic [OUT_CH_W-1:0] ch_q;

   logic                eff_valid;
   logic [DATA_W-1:0]   eff_data;
   logic [ERR_W-1:0]    eff_err;
   logic [IN_CH_W-1:0]  eff_ch;
   logic                eff_sop;
   logic                eff_eop;
   logic                fire;
   logic [SUM_W-1:0]    sum;
   logic                legal;

   logic                push;
   logic                drop_inc;
   logic                latch_ch;
   logic                set_hold;
   logic [ERR_W-1:0]    o_err;
   logic [OUT_CH_W-1:0] o_ch;
   logic                o_sop;
   logic                o_eop;

   // a held beat (SOP that closed an open packet) replays ahead of new input
   assign eff_valid = hold_q | in_valid;
   assign eff_data  = hold_q ? hold_data_q : in_data;
   assign eff_err   = hold_q ? hold_err_q : in_error;
   assign eff_ch    = hold_q ? hold_ch_q : in_channel;
   assign eff_sop   = hold_q | in_startofpacket;
   assign eff_eop   = hold_q ? hold_eop_q : in_endofpacket;
   assign fire      = eff_valid & buf_ready;
   assign in_ready  = buf_ready & ~hold_q;

   assign sum   = {{(SUM_W-IN_CH_W){1'b0}}, eff_ch} + SUM_W'(CH_OFFSET);
   assign legal = (sum <= SUM_W'(MAX_OUT_CH));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (fire) begin
         unique case (state_q)
            ST_PASS: begin
               if (eff_sop || eff_eop) state_d = ST_IDLE;
            end
            default: begin
               if (eff_eop)                state_d = ST_IDLE;
               else if (eff_sop && legal) state_d = ST_PASS;
               else                        state_d = ST_DROP;
            end
         endcase
      end
   end

   always_comb begin
      push     = 1'b0;
      drop_inc = 1'b0;
      latch_ch = 1'b0;
      set_hold = 1'b0;
      o_err    = eff_err;
      o_ch     = ch_q;
      o_sop    = eff_sop;
      o_eop    = eff_eop;
      if (fire) begin
         unique case (state_q)
            ST_PASS: begin
               push = 1'b1;
               if (eff_sop) begin
                  set_hold = 1'b1;
                  o_sop    = 1'b0;
                  o_eop    = 1'b1;
                  o_err[0] = 1'b1;
               end
            end
            default: begin
               if (eff_sop && legal) begin
                  push     = 1'b1;
                  latch_ch = 1'b1;
                  o_ch     = sum[OUT_CH_W-1:0];
               end else if (eff_sop || state_q == ST_IDLE) begin
                  drop_inc = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_q      <= 1'b0;
         hold_data_q <= '0;
         hold_err_q  <= '0;
         hold_ch_q   <= '0;
         hold_eop_q  <= 1'b0;
         ch_q        <= '0;
         drop_count  <= '0;
      end else begin
         if (set_hold) begin
            hold_q      <= 1'b1;
            hold_data_q <= in_data;
            hold_err_q  <= in_error;
            hold_ch_q   <= in_channel;
            hold_eop_q  <= in_endofpacket;
         end else if (fire) begin
            hold_q <= 1'b0;
         end
         if (latch_ch) ch_q <= sum[OUT_CH_W-1:0];
         if (drop_inc && drop_count != {CNT_W{1'b1}})
            drop_count <= drop_count + CNT_W'(1);
      end
   end

   avalon_st_skid_buffer #(
      .WIDTH(BUF_W)
   ) u_skid (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_valid (push),
      .in_ready (buf_ready),
      .in_data  ({eff_data, o_err, o_ch, o_sop, o_eop}),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data ({out_data, out_error, out_channel,
                  out_startofpacket, out_endofpacket})
   );

endmodule
